uart_receiver: RTL and testbench
================================

# uart_receiver

Serial-to-parallel UART receiver that recovers 8-bit frames from the line driven by the team's UART transmitter. It uses the same frame and bit timing: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), and a fixed number of clocks per bit. The block sits on the input side of the link. It presents each received byte with a one-cycle valid strobe to the downstream Hamming decoder and reports framing errors.

## Interface
- `CLKS_PER_BIT`, default 8: clocks per bit period. Must be a power of two and at least 4. Must match the transmitter.
- `DATA_BITS`, default 8: data bits per frame.
- `clk`  input  1  system clock.
- `rst`  input  1  reset, synchronous and active-high.
- `rx`  input  1  asynchronous serial line; idles high.
- `rx_data`  output  8  last good byte; holds its value until the next good frame.
- `rx_valid`  output  1  one-cycle pulse when `rx_data` is updated.
- `frame_err`  output  1  one-cycle pulse when the stop bit samples 0.
- `rx_busy`  output  1  high in every state except IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer to produce `rx_s`. Both flops reset to 1.
- Counters:
  - `clk_count` runs over 0..CLKS_PER_BIT-1.
  - `bit_count` runs over 0..DATA_BITS-1.
  - `MID` = CLKS_PER_BIT/2 − 1, which is 3 at the default.
- States and transitions:
  - **IDLE**: when `rx_s`==0, go to START with `clk_count`=0.
  - **START**: increment `clk_count`. At `clk_count`==MID, check `rx_s`:
    - 0: go to DATA with `clk_count`=0 and `bit_count`=0.
    - 1: false start; go to IDLE with no pulse.
  - **DATA**: at `clk_count`==CLKS_PER_BIT-1, the sampled bit shifts into the MSB of `shift_reg` (right shift) and `bit_count` increments. After bit DATA_BITS-1 is sampled, go to STOP with `clk_count`=0.
  - **STOP**: at `clk_count`==CLKS_PER_BIT-1, sample the line:
    - 1: `rx_data` ← `shift_reg`, `rx_valid` pulses, go to IDLE.
    - 0: `frame_err` pulses, `rx_data` is unchanged, go to BREAK.
  - **BREAK**: wait until `rx_s`==1, then go to IDLE. This stops a held-low line from retriggering.
- `rx_valid` and `frame_err` are registered and never assert in the same cycle.
- Reset mid-frame: the next edge puts the block in IDLE. All counters, `shift_reg`, `rx_data` and the pulse outputs go to 0. The synchronizer flops go to 1.

## Timing
- Reset values: `rx_data`=0x00, `rx_valid`=0, `frame_err`=0, `rx_busy`=0.
- Let T be the IDLE cycle in which `rx_s` is first 0. At the default parameters:
  - START occupies T+1..T+4; the start check happens at T+4.
  - Bit k is sampled at T+12+8k, so bit 7 is sampled at T+68.
  - The stop bit is sampled at T+76.
  - `rx_valid` or `frame_err` is high in cycle T+77.
- The `rx` pin to `rx_s` path adds 2 cycles of latency.
- After T+77 the block is back in IDLE and accepts a new start bit immediately. This allows a start bit that follows right after the transmitter's DONE/IDLE stop period.
- A low pulse on `rx_s` lasting 4 cycles or less, with the line back high at the MID check, is rejected.

## Configuration
- `UART_RX_MAJORITY_EN`:
  - Defined: each data and stop bit is the 2-of-3 majority of `rx_s` at `clk_count` = CLKS_PER_BIT-3, -2 and -1. The decision is made at CLKS_PER_BIT-1.
  - Undefined: a single sample at `clk_count`==CLKS_PER_BIT-1.
- The start-bit check is a single sample in both cases.
- Cycle timing is identical with and without the macro.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum (IDLE, START, DATA, STOP, BREAK; 3 bits);
  - the default `CLKS_PER_BIT`=8 and `DATA_BITS`=8, shared with the transmitter;
  - the `START_BIT`=0 and `STOP_BIT`=1 constants.
- Sub-module `uart_rx_sync`: 2-flop synchronizer with parameterized reset value 1.

## Test plan
- Drive frame 0xA5 at 8 clk/bit → `rx_valid` for exactly 1 cycle at T+77, `rx_data`=0xA5, `frame_err`=0.
- Low glitch of 3 cycles on idle `rx` → START then back to IDLE; no `rx_valid` or `frame_err`; `rx_data` unchanged.
- Frame 0x3C with stop bit 0, held low 20 more cycles, then high, then frame 0x81 → `frame_err` pulse, `rx_data` stays at its prior value, block waits in BREAK, then `rx_valid` with 0x81.
- Back-to-back 0x00 then 0xFF with no idle gap beyond one stop bit → two `rx_valid` pulses 80 cycles apart, values 0x00 and 0xFF.
- Assert `rst` during bit 4 of a frame → next cycle all outputs are 0 and state is IDLE; a following frame 0x5A is received correctly.
- With `UART_RX_MAJORITY_EN`: 1-cycle inverted glitch at the final sample point of bit 2 in 0xFF → `rx_data`=0xFF. Without the macro: `rx_data`=0xFB.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions: receiver state encoding, default
//                link timing shared with the transmitter, frame bit levels and
//                a 2-of-3 majority helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int DEF_CLKS_PER_BIT = 8;
    localparam int DEF_DATA_BITS    = 8;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    // 2-of-3 vote used when several samples of one bit are taken.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_sync
//  Description : Two-flop synchronizer for an asynchronous single-bit input.
//                Both flops load RESET_VAL on reset so an idle-high line does
//                not produce a spurious edge when reset is released.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back capture stages to let metastability resolve.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : uart_receiver
//  Description : UART receiver, 1 start / DATA_BITS data (LSB first) / 1 stop.
//                Emits a one-cycle rx_valid with the received byte, or a
//                one-cycle frame_err when the stop bit reads low, after which
//                it waits for the line to return high before re-arming.
//  Config      : define UART_RX_MAJORITY_EN to decide each data/stop bit by a
//                2-of-3 vote over the last three clocks of the bit period.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEF_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 rx_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] c_mid      = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] c_last     = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] c_bit_last = BW'(DATA_BITS - 1);

    logic                 rx_s;
    state_t               state_q, state_d;
    logic [CW-1:0]        clk_count_q, clk_count_d;
    logic [BW-1:0]        bit_count_q, bit_count_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 bit_tick;
    logic                 bit_val;

    uart_rx_sync #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx),
        .q_o (rx_s)
    );

    // End of a data or stop bit period: the point where the bit is decided.
    assign bit_tick = (clk_count_q == c_last);

`ifdef UART_RX_MAJORITY_EN
    localparam logic [CW-1:0] c_samp0 = CW'(CLKS_PER_BIT - 3);
    localparam logic [CW-1:0] c_samp1 = CW'(CLKS_PER_BIT - 2);

    logic [1:0] samp_q;

    // Capture the two early votes of each data/stop bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            samp_q <= 2'b11;
        end else if (state_q == ST_DATA || state_q == ST_STOP) begin
            if (clk_count_q == c_samp0) samp_q[0] <= rx_s;
            if (clk_count_q == c_samp1) samp_q[1] <= rx_s;
        end
    end

    assign bit_val = majority3(samp_q[0], samp_q[1], rx_s);
`else
    assign bit_val = rx_s;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state decision.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (rx_s == START_BIT) state_d = ST_START;
            ST_START: if (clk_count_q == c_mid)
                          state_d = (rx_s == START_BIT) ? ST_DATA : ST_IDLE;
            ST_DATA:  if (bit_tick && bit_count_q == c_bit_last) state_d = ST_STOP;
            ST_STOP:  if (bit_tick)
                          state_d = (bit_val == STOP_BIT) ? ST_IDLE : ST_BREAK;
            ST_BREAK: if (rx_s == STOP_BIT) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Counters, shift register and result/pulse next values.
    always_comb begin
        clk_count_d = clk_count_q + CW'(1);
        bit_count_d = bit_count_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        valid_d     = 1'b0;
        ferr_d      = 1'b0;
        case (state_q)
            ST_START: begin
                if (clk_count_q == c_mid) begin
                    clk_count_d = '0;
                    bit_count_d = '0;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    clk_count_d = '0;
                    shift_d     = {bit_val, shift_q[DATA_BITS-1:1]};
                    bit_count_d = (bit_count_q == c_bit_last) ? '0 : bit_count_q + BW'(1);
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    clk_count_d = '0;
                    if (bit_val == STOP_BIT) begin
                        rx_data_d = shift_q;
                        valid_d   = 1'b1;
                    end else begin
                        ferr_d    = 1'b1;
                    end
                end
            end
            default: begin
                clk_count_d = '0;
                bit_count_d = '0;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_count_q <= '0;
            bit_count_q <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            valid_q     <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            clk_count_q <= clk_count_d;
            bit_count_q <= bit_count_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            valid_q     <= valid_d;
            ferr_q      <= ferr_d;
        end
    end

    // Outputs.
    always_comb begin
        rx_busy   = (state_q != ST_IDLE);
        rx_data   = rx_data_q;
        rx_valid  = valid_q;
        frame_err = ferr_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_receiver
//  Description : Self-checking bench for uart_receiver. Frames are driven on
//                the rx pin one clock at a time; a monitor logs every
//                rx_valid / frame_err pulse with its cycle number and the
//                steps compare the log against expected byte values and the
//                frame timing (pulse 79 cycles after the first start-bit pin
//                cycle: 2 synchronizer cycles plus T+77).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int collisions = 0;

    int         vcyc_q[$];
    logic [7:0] vdat_q[$];
    int         fcyc_q[$];

    logic [7:0] last_good;

    uart_receiver #(
        .CLKS_PER_BIT (8),
        .DATA_BITS    (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse log, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                vcyc_q.push_back(cyc);
                vdat_q.push_back(rx_data);
            end
            if (frame_err) fcyc_q.push_back(cyc);
            if (rx_valid && frame_err) collisions++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            rx = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one frame on the pin; n0 is the cycle of the first start-bit clock.
    task automatic send_frame(input logic [7:0] b, input logic stopb,
                              input int glitch_at, input int stop_after,
                              output int n0);
        n0 = cyc;
        for (int c = 0; c < 80 && c < stop_after; c++) begin
            logic v;
            if (c < 8)       v = 1'b0;
            else if (c < 72) v = b[(c - 8) / 8];
            else             v = stopb;
            if (c == glitch_at) v = ~v;
            rx = v;
            @(posedge clk);
            #1;
        end
    endtask

    // Expect exactly one good-frame pulse, at the frame's fixed latency.
    task automatic expect_good(input string tag, input logic [7:0] exp, input int n0);
        chk({tag, "_nvalid"}, vcyc_q.size(), 1);
        if (vcyc_q.size() > 0) begin
            chk({tag, "_vcycle"}, vcyc_q[0], n0 + 79);
            chk({tag, "_data"}, {24'd0, vdat_q[0]}, {24'd0, exp});
        end
        chk({tag, "_nferr"}, fcyc_q.size(), 0);
        chk({tag, "_rxdata"}, {24'd0, rx_data}, {24'd0, exp});
        last_good = exp;
        vcyc_q.delete();
        vdat_q.delete();
        fcyc_q.delete();
    endtask

    initial begin
        int         n0, n1, p1;
        logic [7:0] b, exp_b;

        rst = 1'b1;
        rx  = 1'b1;
        last_good = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rx_data",   {24'd0, rx_data}, 32'h0);
        chk("rst_rx_valid",  {31'd0, rx_valid}, 32'h0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'h0);
        chk("rst_rx_busy",   {31'd0, rx_busy}, 32'h0);
        rst = 1'b0;
        idle(5);

        // Basic frame.
        send_frame(8'hA5, 1'b1, -1, 80, n0);
        expect_good("a5", 8'hA5, n0);
        idle(3);

        // Short low glitch: must be rejected without any pulse.
        rx = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rx = 1'b1;
        @(posedge clk); #1;
        chk("glitch_busy", {31'd0, rx_busy}, 32'h1);
        idle(10);
        chk("glitch_idle",   {31'd0, rx_busy}, 32'h0);
        chk("glitch_nvalid", vcyc_q.size(), 0);
        chk("glitch_nferr",  fcyc_q.size(), 0);
        chk("glitch_rxdata", {24'd0, rx_data}, {24'd0, last_good});

        // Framing error, held-low line, then recovery.
        send_frame(8'h3C, 1'b0, -1, 80, n0);
        chk("ferr_count", fcyc_q.size(), 1);
        if (fcyc_q.size() > 0) chk("ferr_cycle", fcyc_q[0], n0 + 79);
        chk("ferr_nvalid", vcyc_q.size(), 0);
        chk("ferr_rxdata", {24'd0, rx_data}, {24'd0, last_good});
        fcyc_q.delete();
        rx = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        chk("break_busy",   {31'd0, rx_busy}, 32'h1);
        chk("break_nferr",  fcyc_q.size(), 0);
        chk("break_nvalid", vcyc_q.size(), 0);
        idle(4);
        chk("break_exit", {31'd0, rx_busy}, 32'h0);
        send_frame(8'h81, 1'b1, -1, 80, n0);
        expect_good("f81", 8'h81, n0);

        // Back-to-back frames with only one stop bit between them.
        send_frame(8'h00, 1'b1, -1, 80, n0);
        p1 = (vcyc_q.size() > 0) ? vcyc_q[0] : -1000;
        expect_good("b2b0", 8'h00, n0);
        send_frame(8'hFF, 1'b1, -1, 80, n1);
        if (vcyc_q.size() > 0) chk("b2b_spacing", vcyc_q[0] - p1, 80);
        expect_good("b2bF", 8'hFF, n1);
        idle(2);

        // Reset in the middle of bit 4.
        send_frame(8'hC3, 1'b1, -1, 43, n0);
        chk("mid_busy", {31'd0, rx_busy}, 32'h1);
        rst = 1'b1;
        rx  = 1'b1;
        @(posedge clk); #1;
        chk("midrst_rx_data",   {24'd0, rx_data}, 32'h0);
        chk("midrst_rx_valid",  {31'd0, rx_valid}, 32'h0);
        chk("midrst_frame_err", {31'd0, frame_err}, 32'h0);
        chk("midrst_rx_busy",   {31'd0, rx_busy}, 32'h0);
        rst = 1'b0;
        vcyc_q.delete();
        vdat_q.delete();
        fcyc_q.delete();
        idle(3);
        send_frame(8'h5A, 1'b1, -1, 80, n0);
        expect_good("f5a", 8'h5A, n0);
        idle(2);

        // One-cycle inversion at the final sample clock of bit 2.
        send_frame(8'hFF, 1'b1, 28, 80, n0);
`ifdef UART_RX_MAJORITY_EN
        exp_b = 8'hFF;
`else
        exp_b = 8'hFB;
`endif
        expect_good("vote", exp_b, n0);
        idle(2);

        // Random bytes with random idle gaps.
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom_range(0, 255));
            idle(int'($urandom_range(0, 4)));
            send_frame(b, 1'b1, -1, 80, n0);
            expect_good($sformatf("rnd%0d", i), b, n0);
        end
        idle(4);
        chk("end_idle", {31'd0, rx_busy}, 32'h0);
        chk("no_collision", collisions, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
